// File: rtl/dualram_pingpong_ctrl.sv
// rtl/dualram_pingpong_ctrl.sv - ping-pong block sequencer between a word stream and the dual-bank dualram
module dualram_pingpong_ctrl #(
    parameter int AW     = 3,
    parameter int RD_LAT = 1,
    parameter int FD     = RD_LAT + 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    input  logic [7:0]    in_be,
    input  logic          flush,
    output logic          rnw,
    output logic [AW-1:0] wa,
    output logic [63:0]   di,
    output logic [7:0]    be,
    output logic          din_valid,
    output logic [AW-1:0] ra,
    input  logic [63:0]   dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_data,
    output logic          out_last
);
    localparam int          DEPTH    = 2 ** AW;
    localparam int          PW       = (FD > 1) ? $clog2(FD) : 1;
    localparam int          CW       = $clog2(FD + 1);
    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    typedef enum logic       {W_FILL, W_FULL}           w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} r_state_t;

    w_state_t      w_state, w_next;
    r_state_t      r_state, r_next;
    logic [AW:0]   wr_cnt, blk_len, rd_cnt, rd_len;
    logic          accept, block_done, swap, issue, last_issue, push, pop;
    logic [RD_LAT:0] pipe_v, pipe_l;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   in_flight;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [63:0]   fifo_data [FD];
    logic          fifo_last [FD];

    assign in_ready  = (w_state == W_FILL);
    assign swap      = (w_state == W_FULL) && (r_state == R_IDLE);
    assign push      = pipe_v[RD_LAT];
    assign pop       = out_valid && out_ready;
    assign out_valid = (fifo_cnt != '0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = out_valid && fifo_last[rd_ptr];

    always_comb begin
        accept     = in_valid && in_ready;
        block_done = (accept && wr_cnt == LAST_IDX) || (flush && (accept || wr_cnt != '0));
        w_next     = w_state;
        case (w_state)
            W_FILL:  if (block_done) w_next = W_FULL;
            W_FULL:  if (swap) w_next = W_FILL;
            default: w_next = W_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_FILL;
            wr_cnt    <= '0;
            blk_len   <= '0;
            rnw       <= 1'b0;
            wa        <= '0;
            di        <= '0;
            be        <= '1;
            din_valid <= 1'b0;
        end else begin
            w_state   <= w_next;
            din_valid <= accept;
            if (accept) begin
                wa <= wr_cnt[AW-1:0];
                di <= in_data;
                be <= ~in_be;
            end
            if (swap) begin
                wr_cnt <= '0;
                rnw    <= ~rnw;
            end else if (accept) begin
                wr_cnt <= wr_cnt + ONE;
            end
            if (w_state == W_FILL && block_done)
                blk_len <= wr_cnt + (AW+1)'(accept);
        end
    end

    // Credit counts words in the read pipeline plus FIFO, net of this cycle's pop.
    always_comb begin
        in_flight  = (CW+1)'($countones(pipe_v)) + (CW+1)'(fifo_cnt);
        issue      = (r_state == R_ISSUE) && (in_flight < (CW+1)'(FD) + (CW+1)'(pop));
        last_issue = issue && (rd_cnt == rd_len - ONE);
        r_next     = r_state;
        case (r_state)
            R_IDLE:  if (swap) r_next = R_ISSUE;
            R_ISSUE: if (last_issue) r_next = R_DRAIN;
            R_DRAIN: if (pipe_v == '0 && fifo_cnt == '0) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            rd_cnt  <= '0;
            rd_len  <= '0;
            ra      <= '0;
            pipe_v  <= '0;
            pipe_l  <= '0;
        end else begin
            r_state <= r_next;
            pipe_v  <= {pipe_v[RD_LAT-1:0], issue};
            pipe_l  <= {pipe_l[RD_LAT-1:0], last_issue};
            if (swap) begin
                rd_len <= blk_len;
                rd_cnt <= '0;
            end else if (issue) begin
                ra     <= rd_cnt[AW-1:0];
                rd_cnt <= rd_cnt + ONE;
            end
        end
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= dout;
            fifo_last[wr_ptr] <= pipe_l[RD_LAT];
        end
    end
endmodule

// File: doc/dualram_pingpong_ctrl.md
Name: dualram_pingpong_ctrl

Overview:
Drives the 64-bit ping-pong dual-bank RAM (dualram) from a streaming producer and a streaming consumer.
- Write side: accepts words on a valid/ready stream and writes them into the current write bank.
- Read side: reads the previously filled block back out of the other bank and presents it as a valid/ready stream with a last-word marker.
- Bank roles swap on block boundaries.
- Sits between the host data path and dualram, in place of hand-driven rnw/wa/ra sequencing.

Parameters:
AW, 3, RAM address width; block depth = 2**AW words (8)
RD_LAT, 1, clk cycles from ra presented to valid dout
FD, RD_LAT+2, output FIFO depth (read credits)

Ports:
clk  in  1  system clock; also drives dualram clk and pci_clk
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  producer word valid
in_ready  out  1  controller can accept a word
in_data  in  64  producer word
in_be  in  8  active-high byte enables for in_data
flush  in  1  single-cycle pulse; close the current partial block
rnw  out  1  bank select to dualram; 0 = write ram1/read ram2, 1 = write ram2/read ram1
wa  out  AW  dualram write address
di  out  64  dualram write data
be  out  8  dualram byte enables, active-low (0 = write byte)
din_valid  out  1  dualram write strobe
ra  out  AW  dualram read address
dout  in  64  dualram read data
out_valid  out  1  output word valid
out_ready  in  1  consumer ready
out_data  out  64  output word
out_last  out  1  final word of a block

Behaviour:
- Reset (async, rst_n=0) values:
  - rnw=0, wa=0, ra=0, di=0, be=8'hFF, din_valid=0.
  - in_ready=1, out_valid=0, out_last=0.
  - FIFO empty; both FSMs in initial state; any in-flight block is discarded.
- Write FSM, states W_FILL and W_FULL:
  - W_FILL: in_ready=1. On in_valid&in_ready, the next edge registers wa=wr_cnt, di=in_data, be=~in_be, din_valid=1, and increments wr_cnt. din_valid=0 in any cycle with no accept.
  - Go to W_FULL when the accepted word has wr_cnt = 2**AW-1, or when flush is seen with wr_cnt>0. A flush together with an accept counts that word. A flush with wr_cnt=0 and no accept is ignored.
  - W_FULL: in_ready=0. Block length is latched as blk_len (1..2**AW).
- Swap: occurs on the edge where write FSM is in W_FULL and read FSM is in R_IDLE.
  - rnw toggles; wr_cnt←0; write FSM→W_FILL.
  - Read FSM→R_ISSUE with rd_len←blk_len and rd_cnt←0.
  - This gives a minimum one-cycle in_ready bubble per block.
  - While the read side is busy, W_FULL holds indefinitely (backpressure to producer).
- Read FSM, states R_IDLE, R_ISSUE, R_DRAIN:
  - R_ISSUE: each cycle with credit available (outstanding+FIFO occupancy < FD), drive ra=rd_cnt, tag the entry last=(rd_cnt==rd_len-1), then rd_cnt++.
  - An RD_LAT-deep valid/last shift pipeline captures dout into the FIFO.
  - After the last address is issued, go to R_DRAIN. R_DRAIN→R_IDLE when the pipeline and FIFO are both empty and the final word has handshaken.
  - ra holds its last value when not issuing.
- Output: out_valid = FIFO non-empty; out_data/out_last come from the FIFO head; pop on out_valid&out_ready. The FIFO never overflows because of the credit rule.
- First block after reset: the read bank holds nothing valid, so nothing is read until the first swap.
- flush asserted in W_FULL is ignored.
- Counters wrap only via the explicit reset to 0 at swap; wa and ra never exceed rd_len-1.

Test Plan:
- Reset mid-block: accept 3 words, pull rst_n low asynchronously → all outputs at reset values immediately; after release, the next 8-word block writes wa 0..7 starting from 0.
- Full block streaming: 8 words 64'h123456789abcdef0, 64'h7E6A4719E7B99682, … with out_ready=1 → wa 0..7 with be=8'h00, then rnw 0→1, ra 0..7; out_data matches in order with out_last on word 8; in_ready low exactly one cycle.
- Continuous ping-pong: 4 back-to-back blocks → rnw toggles 0,1,0,1; each block is read intact from the opposite bank while the next block is written.
- Backpressure: out_ready=0 after the second block swaps → at most FD words buffered, third block fills then in_ready stays 0; release out_ready → order is preserved and the swap follows the final pop.
- Partial flush: 3 words then a flush pulse → swap; exactly 3 words out, out_last on the third. A flush with 0 words produces no swap.
- Byte enables: in_be=8'h0F → be=8'hF0 on the RAM port; the readback shows only the low 4 bytes updated against the previous bank contents.
